// File: rtl/traffic_light_ctrl_n.sv
// traffic_light_ctrl_n
// N-approach traffic-light sequencer: ALLRED -> GREEN -> YELLOW -> ALLRED.
// Each phase has a programmable duration counted in en ticks.
// Vehicle demand is latched per approach. With SKIP_EMPTY=1, idle
// approaches are skipped, and the controller rests on green while no
// other approach has demand.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_ALLRED | all lamps red, clearance interval, selects next approach
// S_GREEN  | active approach green; may rest here when no other demand
// S_YELLOW | active approach yellow, always followed by S_ALLRED
module traffic_light_ctrl_n #(
    parameter int NUM_DIR      = 4,
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int SKIP_EMPTY   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_DIR-1:0]         sensor,
    output logic [NUM_DIR-1:0]         green,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         red,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic [1:0]                 phase,
    output logic [NUM_DIR-1:0]         req_pend
);

    localparam int DIR_W = $clog2(NUM_DIR);
    localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIR - 1);

    typedef enum logic [1:0] {
        S_ALLRED = 2'b00,
        S_GREEN  = 2'b01,
        S_YELLOW = 2'b10
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   timer, timer_nxt;
    logic [DIR_W-1:0]   dir_nxt;
    logic [DIR_W-1:0]   next_sel;
    logic [NUM_DIR-1:0] req_nxt;
    logic [NUM_DIR-1:0] active_mask;
    logic [NUM_DIR-1:0] set_mask;
    logic [NUM_DIR-1:0] clr_mask;
    logic               other_req;
    logic               enter_green;

    // Descending rotation with wrap; NUM_DIR need not be a power of two.
    function automatic logic [DIR_W-1:0] dir_dec(input logic [DIR_W-1:0] d);
        return (d == '0) ? LAST_DIR : d - 1'b1;
    endfunction

    assign active_mask = NUM_DIR'(1) << active_dir;
    assign other_req   = |(req_pend & ~active_mask);

    // Next-approach selection: walk active_dir-1, active_dir-2, ... and take the
    // first pending approach; the current approach is visited last.
    always_comb begin
        logic [DIR_W-1:0] cand;
        logic             found;
        next_sel = dir_dec(active_dir);
        cand     = active_dir;
        found    = 1'b0;
        if (SKIP_EMPTY != 0) begin
            for (int k = 0; k < NUM_DIR; k++) begin
                cand = dir_dec(cand);
                if (!found && req_pend[cand]) begin
                    next_sel = cand;
                    found    = 1'b1;
                end
            end
        end
    end

    // Next-state and phase timer; everything holds on cycles without en.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        dir_nxt     = active_dir;
        enter_green = 1'b0;
        if (en) begin
            if (timer != '0) begin
                timer_nxt = timer - 1'b1;
            end else begin
                case (state)
                    S_ALLRED: begin
                        state_nxt   = S_GREEN;
                        timer_nxt   = CNT_W'(GREEN_TICKS - 1);
                        dir_nxt     = next_sel;
                        enter_green = 1'b1;
                    end
                    S_GREEN: begin
                        if ((SKIP_EMPTY != 0) && !other_req) begin
                            timer_nxt = CNT_W'(GREEN_TICKS - 1);
                        end else begin
                            state_nxt = S_YELLOW;
                            timer_nxt = CNT_W'(YELLOW_TICKS - 1);
                        end
                    end
                    S_YELLOW: begin
                        state_nxt = S_ALLRED;
                        timer_nxt = CNT_W'(ALLRED_TICKS - 1);
                    end
                    default: begin
                        state_nxt = S_ALLRED;
                        timer_nxt = CNT_W'(ALLRED_TICKS - 1);
                    end
                endcase
            end
        end
    end

    // Demand latch: the active approach cannot re-request while green, and the
    // clear on green entry beats a same-cycle sensor hit.
    always_comb begin
        set_mask = sensor & ~((state == S_GREEN) ? active_mask : '0);
        clr_mask = enter_green ? (NUM_DIR'(1) << next_sel) : '0;
        req_nxt  = (req_pend | set_mask) & ~clr_mask;
    end

    // State, timer, served approach and request register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_ALLRED;
            timer      <= CNT_W'(ALLRED_TICKS - 1);
            active_dir <= '0;
            req_pend   <= '0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            active_dir <= dir_nxt;
            req_pend   <= req_nxt;
        end
    end

    // Lamps are decoded from registered state only.
    always_comb begin
        green  = (state == S_GREEN)  ? active_mask : '0;
        yellow = (state == S_YELLOW) ? active_mask : '0;
        red    = ~(green | yellow);
        phase  = state;
    end

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Directed bench for traffic_light_ctrl_n: a 3-approach fixed rotation
// instance (a) and a 4-approach demand-skipping instance (b).
module tb_traffic_light_ctrl_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;
    bit gate = 1'b0;

    logic       rst_a, en_a;
    logic [2:0] sensor_a, green_a, yellow_a, red_a, req_a;
    logic [1:0] dir_a, phase_a;

    logic       rst_b, en_b;
    logic [3:0] sensor_b, green_b, yellow_b, red_b, req_b;
    logic [1:0] dir_b, phase_b;

    traffic_light_ctrl_n #(
        .NUM_DIR(3), .CNT_W(8), .GREEN_TICKS(20), .YELLOW_TICKS(4),
        .ALLRED_TICKS(2), .SKIP_EMPTY(0)
    ) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .sensor(sensor_a),
        .green(green_a), .yellow(yellow_a), .red(red_a),
        .active_dir(dir_a), .phase(phase_a), .req_pend(req_a)
    );

    traffic_light_ctrl_n #(
        .NUM_DIR(4), .CNT_W(8), .GREEN_TICKS(20), .YELLOW_TICKS(4),
        .ALLRED_TICKS(2), .SKIP_EMPTY(1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .sensor(sensor_b),
        .green(green_b), .yellow(yellow_b), .red(red_b),
        .active_dir(dir_b), .phase(phase_b), .req_pend(req_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // en pattern for instance a: always high, or high one cycle in four
    task automatic step_a();
        en_a = gate ? ((cyc % 4) == 3) : 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_a(input string tag, input int n, input logic [2:0] g,
                         input logic [2:0] y, input logic [1:0] ph, input logic [1:0] d);
        logic [2:0] r;
        r = ~(g | y);
        for (int i = 0; i < n; i++) begin
            chk({tag, " green"},  32'(green_a),  32'(g));
            chk({tag, " yellow"}, 32'(yellow_a), 32'(y));
            chk({tag, " red"},    32'(red_a),    32'(r));
            chk({tag, " phase"},  32'(phase_a),  32'(ph));
            chk({tag, " dir"},    32'(dir_a),    32'(d));
            step_a();
        end
    endtask

    task automatic run_b(input string tag, input int n, input logic [3:0] g,
                         input logic [3:0] y, input logic [1:0] ph, input logic [1:0] d);
        logic [3:0] r;
        r = ~(g | y);
        for (int i = 0; i < n; i++) begin
            chk({tag, " green"},  32'(green_b),  32'(g));
            chk({tag, " yellow"}, 32'(yellow_b), 32'(y));
            chk({tag, " red"},    32'(red_b),    32'(r));
            chk({tag, " phase"},  32'(phase_b),  32'(ph));
            chk({tag, " dir"},    32'(dir_b),    32'(d));
            en_b = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic do_reset_a();
        rst_a = 1'b1;
        en_a  = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        cyc   = 0;
    endtask

    task automatic do_reset_b();
        rst_b = 1'b1;
        en_b  = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; sensor_a = '0;
        rst_b = 1'b1; en_b = 1'b0; sensor_b = '0;
        repeat (2) @(negedge clk);

        // Default rotation, en high: 2 -> 1 -> 0 -> 2
        do_reset_a();
        chk("a reset req", 32'(req_a), 32'h0);
        run_a("a ar0", 2, 3'b000, 3'b000, 2'b00, 2'd0);
        run_a("a g2",  20, 3'b100, 3'b000, 2'b01, 2'd2);
        run_a("a y2",  4, 3'b000, 3'b100, 2'b10, 2'd2);
        run_a("a ar2", 2, 3'b000, 3'b000, 2'b00, 2'd2);
        run_a("a g1",  20, 3'b010, 3'b000, 2'b01, 2'd1);
        run_a("a y1",  4, 3'b000, 3'b010, 2'b10, 2'd1);
        run_a("a ar1", 2, 3'b000, 3'b000, 2'b00, 2'd1);
        run_a("a g0",  20, 3'b001, 3'b000, 2'b01, 2'd0);
        run_a("a y0",  4, 3'b000, 3'b001, 2'b10, 2'd0);
        run_a("a ar0b", 2, 3'b000, 3'b000, 2'b00, 2'd0);
        run_a("a g2wrap", 1, 3'b100, 3'b000, 2'b01, 2'd2);

        // Latch some demand, then reset in YELLOW with timer=2
        sensor_a = 3'b011;
        step_a();
        sensor_a = 3'b000;
        run_a("a g2b", 18, 3'b100, 3'b000, 2'b01, 2'd2);
        chk("a req latched", 32'(req_a), 32'h3);
        run_a("a y2b", 1, 3'b000, 3'b100, 2'b10, 2'd2);
        chk("a y timer2 yellow", 32'(yellow_a), 32'h4);
        do_reset_a();
        chk("a midrst red",    32'(red_a),    32'h7);
        chk("a midrst green",  32'(green_a),  32'h0);
        chk("a midrst yellow", 32'(yellow_a), 32'h0);
        chk("a midrst phase",  32'(phase_a),  32'h0);
        chk("a midrst dir",    32'(dir_a),    32'h0);
        chk("a midrst req",    32'(req_a),    32'h0);
        run_a("a restart ar", 2, 3'b000, 3'b000, 2'b00, 2'd0);
        run_a("a restart g2", 20, 3'b100, 3'b000, 2'b01, 2'd2);
        run_a("a restart y2", 1, 3'b000, 3'b100, 2'b10, 2'd2);

        // en one cycle in four: phases stretch 4x, sensor still latched
        do_reset_a();
        gate = 1'b1;
        sensor_a = 3'b001;
        run_a("a gated ar", 1, 3'b000, 3'b000, 2'b00, 2'd0);
        sensor_a = 3'b000;
        chk("a gated req latch", 32'(req_a), 32'h1);
        run_a("a gated ar", 7, 3'b000, 3'b000, 2'b00, 2'd0);
        run_a("a gated g2", 80, 3'b100, 3'b000, 2'b01, 2'd2);
        run_a("a gated y2", 16, 3'b000, 3'b100, 2'b10, 2'd2);
        run_a("a gated ar2", 8, 3'b000, 3'b000, 2'b00, 2'd2);
        run_a("a gated g1", 1, 3'b010, 3'b000, 2'b01, 2'd1);
        chk("a gated req held", 32'(req_a), 32'h1);
        gate  = 1'b0;
        rst_a = 1'b1;

        // Skip idle approaches: only approach 1 requests
        do_reset_b();
        chk("b reset req", 32'(req_b), 32'h0);
        sensor_b = 4'b0010;
        run_b("b ar", 1, 4'b0000, 4'b0000, 2'b00, 2'd0);
        sensor_b = 4'b0000;
        chk("b req1 set", 32'(req_b), 32'h2);
        run_b("b ar", 1, 4'b0000, 4'b0000, 2'b00, 2'd0);
        chk("b req1 clr", 32'(req_b), 32'h0);
        run_b("b rest g1", 30, 4'b0010, 4'b0000, 2'b01, 2'd1);

        // Demand on 3 breaks the rest once the current green timer expires
        sensor_b = 4'b1000;
        run_b("b brk g1", 1, 4'b0010, 4'b0000, 2'b01, 2'd1);
        sensor_b = 4'b0000;
        chk("b req3 set", 32'(req_b), 32'h8);
        run_b("b brk g1", 9, 4'b0010, 4'b0000, 2'b01, 2'd1);
        run_b("b y1", 4, 4'b0000, 4'b0010, 2'b10, 2'd1);
        run_b("b ar1", 2, 4'b0000, 4'b0000, 2'b00, 2'd1);
        chk("b req3 clr", 32'(req_b), 32'h0);

        // Sensor 2 on the exact GREEN-entry edge for approach 2: clear wins
        sensor_b = 4'b0100;
        run_b("b g3", 1, 4'b1000, 4'b0000, 2'b01, 2'd3);
        sensor_b = 4'b0000;
        chk("b req2 set", 32'(req_b), 32'h4);
        run_b("b g3", 19, 4'b1000, 4'b0000, 2'b01, 2'd3);
        run_b("b y3", 4, 4'b0000, 4'b1000, 2'b10, 2'd3);
        run_b("b ar3", 1, 4'b0000, 4'b0000, 2'b00, 2'd3);
        sensor_b = 4'b0100;
        run_b("b ar3 exit", 1, 4'b0000, 4'b0000, 2'b00, 2'd3);
        chk("b simul clr", 32'(req_b), 32'h0);
        run_b("b g2", 3, 4'b0100, 4'b0000, 2'b01, 2'd2);
        chk("b green blocks own req", 32'(req_b), 32'h0);
        sensor_b = 4'b0000;
        run_b("b g2 rest", 1, 4'b0100, 4'b0000, 2'b01, 2'd2);
        chk("b final req", 32'(req_b), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl_n.md
# traffic_light_ctrl_n

Parametrised N-approach traffic-light sequencer. Successor to the fixed 3-way one-hot rotator. Adds:
- a real clock and synchronous reset,
- per-phase programmable durations (green, yellow, all-red),
- latched vehicle-demand requests with optional skipping of idle approaches and rest-on-green.

Sits between the intersection sensor front end and the lamp drivers; `en` is the shared slow tick (e.g. 1 Hz strobe) from the timebase.

## Interface
- NUM_DIR, 4, number of approaches (2..16); one lamp group per approach
- CNT_W, 8, phase timer width; every *_TICKS-1 must fit in CNT_W bits
- GREEN_TICKS, 20, green duration in `en` ticks (>=1)
- YELLOW_TICKS, 4, yellow duration in `en` ticks (>=1)
- ALLRED_TICKS, 2, all-red clearance duration in `en` ticks (>=1)
- SKIP_EMPTY, 0, 1 = serve only approaches with pending demand, rest on green when no other demand

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  timer tick enable; state and timer advance only on cycles with en=1
- sensor  in  NUM_DIR  per-approach vehicle demand, level or pulse, sampled every clk
- green  out  NUM_DIR  one-hot green lamp, active approach only
- yellow  out  NUM_DIR  one-hot yellow lamp, active approach only
- red  out  NUM_DIR  red lamps, = ~(green | yellow)
- active_dir  out  $clog2(NUM_DIR)  index of approach currently or last served
- phase  out  2  00=ALLRED, 01=GREEN, 10=YELLOW
- req_pend  out  NUM_DIR  latched demand register

## Operation
- FSM states: ALLRED, GREEN, YELLOW. Down-counter `timer` is loaded with DURATION-1 on entry to each state.
- On a cycle with en=1:
  - timer != 0: decrement.
  - timer == 0: transition.
- On a cycle with en=0: FSM and timer hold. Request latching continues.
- ALLRED -> GREEN: active_dir <= selected next approach.
- GREEN -> YELLOW, same approach, with one exception:
  - SKIP_EMPTY=1 and req_pend has no bit set other than active_dir: stay GREEN, reload GREEN_TICKS-1 (rest on green).
- YELLOW -> ALLRED, always.
- Next-approach selection is a descending rotation with wrap: candidates active_dir-1, active_dir-2, …, mod NUM_DIR.
  - SKIP_EMPTY=0: next = (active_dir-1) mod NUM_DIR, unconditionally.
  - SKIP_EMPTY=1: next = first candidate in that order with req_pend set, the current approach checked last. If none is set, next = (active_dir-1) mod NUM_DIR.
- Requests:
  - req_pend[i] <= 1 when sensor[i]=1.
  - req_pend[i] <= 0 on the cycle the FSM enters GREEN for approach i.
  - Clear wins over a simultaneous set for that approach.
  - While approach i is GREEN, sensor[i] does not set req_pend[i].
- Lamp invariants:
  - At most one bit of green|yellow is set.
  - green and yellow are never both set.
  - red is all-ones in ALLRED.
- All outputs are registered or decoded from registered state only; no combinational path from sensor or en to the lamps.

## Timing
- Reset (rst=1 at a clk edge) forces, at that edge:
  - phase=ALLRED, timer=ALLRED_TICKS-1
  - active_dir=0, req_pend=0
  - green=0, yellow=0, red=all-ones
- Reset takes precedence over en and sensor. Reset mid-phase aborts the phase immediately (lamps go all-red on the same edge).
- Each phase lasts exactly DURATION en-qualified cycles. With en tied high: GREEN = GREEN_TICKS clk cycles, YELLOW = YELLOW_TICKS, ALLRED = ALLRED_TICKS.
- First green after reset (SKIP_EMPTY=0): approach NUM_DIR-1, after ALLRED_TICKS enabled cycles. Subsequent order: NUM_DIR-2, …, 0, NUM_DIR-1, …
- A sensor pulse is visible in req_pend one clk after it is sampled. A request landing on the ALLRED-exit edge is not considered until the next selection.
- Phase change, active_dir and lamp outputs all update on the same edge.

## Test plan
- Reset/default rotation: NUM_DIR=3, en=1, defaults, SKIP_EMPTY=0 → all red for 2 cycles, then green=100 for 20, yellow=100 for 4, red 2, then green=010, then 001, then 100 again.
- Enable gating: en toggled 1-of-4 cycles → every phase lasts 4× its tick count. Outputs are frozen while en=0 but sensor is still latched into req_pend.
- Skip idle approaches: NUM_DIR=4, SKIP_EMPTY=1, pulse sensor[1] only → after reset ALLRED, green=0010. req_pend[1] clears on entry. With no further demand, green=0010 persists beyond 20 ticks (rest on green).
- Demand break-out of rest: while resting green on 1, pulse sensor[3] → current green runs to its timer expiry, then yellow (4), all-red (2), green=1000.
- Simultaneous set/clear: assert sensor[2] on the exact cycle the FSM enters GREEN for approach 2 → req_pend[2]=0 afterwards.
- Reset mid-phase: assert rst during YELLOW (timer=2) → next edge shows red=all-ones, phase=00, active_dir=0, req_pend=0. Rotation restarts as in scenario 1.
